// File: rtl/axis_multi_accumulator_if.sv
// AXI-Stream style beat bundle shared by the accumulator's sink and source.
// The master drives valid/data/dest/last, the slave returns ready.
interface axis_multi_accumulator_if #(
  parameter int DATA_W = 128,
  parameter int DEST_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [DEST_W-1:0] tdest;
  logic              tlast;

  modport master (output tvalid, tdata, tdest, tlast, input tready);
  modport slave  (input tvalid, tdata, tdest, tlast, output tready);
endinterface

// File: rtl/axis_multi_accumulator.sv
// Multi-channel AXI-Stream accumulator. Each channel (selected by tdest)
// keeps a running sum, beat count and overflow flag; a tlast beat emits one
// result beat on the master side and returns that channel to idle.
// Beats addressed to a channel >= NUM_CH are swallowed and flagged.
module axis_multi_accumulator #(
  parameter int DATAW    = 128,
  parameter int SUM_W    = 128,
  parameter int NUM_CH   = 4,
  parameter int DEST_W   = 8,
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_multi_accumulator_if.slave  s_if,
  axis_multi_accumulator_if.master m_if,
  output logic [CNT_W-1:0]      m_tcount_o,
  output logic                  m_tovf_o,
  output logic                  err_dest_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DEST_W:0] NUM_CH_L = NUM_CH[DEST_W:0];

  // Per-channel state; a zero count means the channel is idle.
  logic [SUM_W-1:0] sum_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic             ovf_q [NUM_CH];

  // Result register and error pulse.
  logic              m_tvalid_q;
  logic [SUM_W-1:0]  m_tdata_q;
  logic [DEST_W-1:0] m_tdest_q;
  logic [CNT_W-1:0]  m_tcount_q;
  logic              m_tovf_q;
  logic              err_dest_q;

  logic              ready_s;
  logic              accept_s;
  logic              in_range_s;
  logic [CH_W-1:0]   ch_idx;
  logic [SUM_W:0]    add_ext;
  logic [SUM_W-1:0]  sum_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_d;

  // The input may advance whenever the result slot is empty or being drained.
  assign ready_s    = !rst && (!m_tvalid_q || m_if.tready);
  assign accept_s   = s_if.tvalid && ready_s;
  assign in_range_s = ({1'b0, s_if.tdest} < NUM_CH_L);

  assign s_if.tready = ready_s;
  assign m_if.tvalid = m_tvalid_q;
  assign m_if.tdata  = m_tdata_q;
  assign m_if.tdest  = m_tdest_q;
  assign m_if.tlast  = 1'b1;
  assign m_tcount_o  = m_tcount_q;
  assign m_tovf_o    = m_tovf_q;
  assign err_dest_o  = err_dest_q;

  // Next sum/count/overflow for the channel addressed by the current beat.
  always_comb begin
    ch_idx = '0;
    if (in_range_s) begin
      ch_idx = s_if.tdest[CH_W-1:0];
    end else begin
      ch_idx = '0;
    end
    // One extra bit catches the carry out of the SUM_W-bit accumulator.
    add_ext = {1'b0, sum_q[ch_idx]} + (SUM_W+1)'(s_if.tdata);
    if (SATURATE && add_ext[SUM_W]) begin
      sum_d = '1;
    end else begin
      sum_d = add_ext[SUM_W-1:0];
    end
    if (&cnt_q[ch_idx]) begin
      cnt_d = cnt_q[ch_idx];
    end else begin
      cnt_d = cnt_q[ch_idx] + CNT_W'(1);
    end
    ovf_d = ovf_q[ch_idx] | add_ext[SUM_W] | (&cnt_d);
  end

  // Channel state update, result load/drain and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tdest_q  <= '0;
      m_tcount_q <= '0;
      m_tovf_q   <= 1'b0;
      err_dest_q <= 1'b0;
    end else begin
      err_dest_q <= accept_s && !in_range_s;
      if (accept_s && in_range_s && s_if.tlast) begin
        // Closing beat: publish the result and free the channel in one edge.
        sum_q[ch_idx] <= '0;
        cnt_q[ch_idx] <= '0;
        ovf_q[ch_idx] <= 1'b0;
        m_tvalid_q    <= 1'b1;
        m_tdata_q     <= sum_d;
        m_tdest_q     <= s_if.tdest;
        m_tcount_q    <= cnt_d;
        m_tovf_q      <= ovf_d;
      end else begin
        if (accept_s && in_range_s) begin
          sum_q[ch_idx] <= sum_d;
          cnt_q[ch_idx] <= cnt_d;
          ovf_q[ch_idx] <= ovf_d;
        end
        if (m_tvalid_q && m_if.tready) begin
          m_tvalid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/axis_multi_accumulator.md
Name: axis_multi_accumulator

Overview:
- AXI-Stream sink/source that keeps an independent running sum per channel. The channel is selected by s_tdest.
- When a transaction's tlast beat is accepted, it emits one result beat (sum, beat count, overflow flag) on an AXI-Stream master port.
- Successor to the single-channel terminal adder sink, for use as a RAD-Sim checker/reduction node:
  - multi-channel
  - configurable sum width
  - wrap or saturate mode
  - backpressure-aware output instead of terminating simulation

Parameters:
- DATAW, 128, input tdata width (unsigned addends)
- SUM_W, 128, accumulator/result width; must be >= DATAW
- NUM_CH, 4, number of channels (1..256, need not be a power of 2)
- DEST_W, 8, tdest width; must satisfy 2^DEST_W >= NUM_CH
- CNT_W, 16, beat counter width per channel
- SATURATE, 0, overflow mode: 0 = wrap modulo 2^SUM_W, 1 = clamp to all-ones

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- s_tvalid  input  1  input beat valid
- s_tready  output  1  input ready
- s_tdata  input  DATAW  addend
- s_tdest  input  DEST_W  channel index
- s_tlast  input  1  last beat of a transaction on that channel
- m_tvalid  output  1  result valid
- m_tready  input  1  downstream ready
- m_tdata  output  SUM_W  final sum of the transaction
- m_tdest  output  DEST_W  channel the result belongs to
- m_tcount  output  CNT_W  beats accepted in the transaction, including the tlast beat
- m_tovf  output  1  sum or count overflowed during the transaction
- err_dest  output  1  one-cycle pulse: beat with s_tdest >= NUM_CH was accepted and dropped

Behaviour:
- Reset (rst=1 at clk edge):
  - all per-channel sums, counts and ovf flags := 0
  - m_tvalid := 0; m_tdata/m_tdest/m_tcount/m_tovf := 0
  - err_dest := 0
  - s_tready = 0 while rst=1
- Reset mid-transaction discards partial sums and any pending result; no beat is emitted for it.
- Handshake:
  - s_tready = !rst && (!m_tvalid || m_tready), combinational.
  - Beat accepted iff s_tvalid && s_tready at the clk edge.
  - AXI rule: m_tvalid, once high, holds m_* stable until m_tready.
- Per-channel FSM, state implied by count: IDLE (count==0) -> ACCUM on a non-last beat; ACCUM stays while non-last beats arrive; any tlast beat -> emit and return to IDLE.
- Arithmetic per accepted beat on channel c (s_tdest < NUM_CH):
  - next = sum[c] + zero-extend(s_tdata) computed at SUM_W+1 bits
  - If bit SUM_W is set, ovf is raised.
  - SATURATE=0: store the low SUM_W bits.
  - SATURATE=1: store all-ones.
  - Count increments and saturates at all-ones; reaching saturation also raises ovf.
  - ovf is sticky for the transaction.
- tlast beat:
  - The result register loads the updated sum, count and ovf (including this beat) and c; m_tvalid=1 on the next cycle (1-cycle latency).
  - Channel c state clears to 0 in the same edge, so the next beat on c starts a fresh transaction.
- Single-beat transaction (tlast on first beat, IDLE): result = s_tdata, count = 1.
- Simultaneous result pop (m_tvalid && m_tready) and new tlast accept: the result register reloads; m_tvalid stays 1, no bubble.
- Pop with no new tlast: m_tvalid := 0.
- Full back-to-back throughput: one beat per cycle while m_tready=1.
- Out-of-range s_tdest:
  - beat accepted (no stall), no state change
  - err_dest pulses 1 the next cycle
  - tlast on such a beat produces no result
- Interleaving channels beat-by-beat is legal; channels never affect each other.

Test Plan:
- Channel 0 beats 5, 7, 9 (tlast on 9), m_tready=1: next cycle m_tvalid=1, m_tdata=21, m_tdest=0, m_tcount=3, m_tovf=0.
- Interleave ch1: 10, 20(last) with ch2: 3, 4, 5(last): results ch1 sum=30 count=2, then ch2 sum=12 count=3, in tlast-acceptance order.
- SUM_W=DATAW=8:
  - SATURATE=0, ch0 200 + 100(last): m_tdata=44, m_tovf=1.
  - SATURATE=1, same stimulus: m_tdata=255, m_tovf=1.
- Hold m_tready=0 with a result pending: s_tready=0 and input stalls. Release m_tready while a tlast beat is presented: pop and reload occur in the same cycle, m_tvalid stays 1.
- NUM_CH=3, beat with s_tdest=3, tlast=1: err_dest pulses once; no m_tvalid; channel 0-2 sums unchanged.
- ch0 beats 1, 2, then rst for one cycle, then 4(last): result sum=4, count=1; m_tvalid=0 throughout the reset cycle.
